spi_cmd_regs: RTL and testbench

- Command decoder and register file directly downstream of the CPLD SPI slave.
- Consumes the slave's per-byte receive strobe and message start/end pulses.
- Interprets the first byte of each message as a command: read/write flag plus 7-bit address. Auto-increments through a small register file.
- Supplies the byte the slave shifts out on MISO for the next byte slot. Exposes register contents and write strobes to the rest of the CPLD (CoCo bus side).

---
 rtl/spi_cmd_regs.sv | 169 ++++++++++++++++
 tb/tb_spi_cmd_regs.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_regs.sv
// Command decoder and register file behind the SPI slave.
// The first byte of a message is {rd_nwr, addr[6:0]}. Later bytes write the
// register file or stream it back, with the address auto-incrementing.
module spi_cmd_regs #(
    parameter int unsigned NREGS     = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  OOR_BYTE  = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 msg_start,
    input  logic                 msg_end,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic [7:0]           tx_data,
    output logic [NREGS*8-1:0]   regs_flat,
    output logic                 wr_strobe,
    output logic [6:0]           wr_addr,
    output logic                 rd_strobe,
    output logic                 err
);

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   regs_q [NREGS];
    logic [DW-1:0]   regs_d [NREGS];
    logic [DW-1:0]   tx_q, tx_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            rd_strobe_q, rd_strobe_d;
    logic            err_q, err_d;

    logic [AW-1:0]   rd_addr_c;
    logic [DW-1:0]   rd_byte_c;

    // Address lies inside the register file (addresses are 7-bit, NREGS <= 128).
    function automatic logic in_range(input logic [AW-1:0] a);
        return (8'(a) < 8'(NREGS));
    endfunction

    // Address whose contents will be presented next: the command address, or the
    // one after the current address while streaming a read.
    always_comb begin
        rd_addr_c = addr_q + 7'd1;
        if (state_q == ST_CMD) begin
            rd_addr_c = rx_data[6:0];
        end
    end

    // Register file read mux; out-of-range addresses read as OOR_BYTE.
    always_comb begin
        rd_byte_c = OOR_BYTE;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (rd_addr_c == 7'(i)) begin
                rd_byte_c = regs_q[i];
            end
        end
    end

    // Next-state and output logic; events ranked msg_start > msg_end > rx_valid.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        tx_d        = tx_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_strobe_d = 1'b0;
        err_d       = err_q;

        if (msg_start) begin
            state_d = ST_CMD;
            tx_d    = SYNC_BYTE;
            err_d   = 1'b0;
        end else if (msg_end) begin
            state_d = ST_IDLE;
            tx_d    = SYNC_BYTE;
        end else if (rx_valid) begin
            case (state_q)
                ST_CMD: begin
                    addr_d = rx_data[6:0];
                    if (rx_data[7]) begin
                        state_d = ST_RD;
                        tx_d    = rd_byte_c;
                        if (!in_range(rx_data[6:0])) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_WR;
                        tx_d    = 8'h00;
                    end
                end
                ST_WR: begin
                    if (in_range(addr_q)) begin
                        for (int unsigned i = 0; i < NREGS; i++) begin
                            if (addr_q == 7'(i)) begin
                                regs_d[i] = rx_data;
                            end
                        end
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    addr_d = addr_q + 7'd1;
                    tx_d   = 8'h00;
                end
                ST_RD: begin
                    rd_strobe_d = 1'b1;
                    addr_d      = rd_addr_c;
                    tx_d        = rd_byte_c;
                    if (!in_range(rd_addr_c)) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            tx_q        <= SYNC_BYTE;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            rd_strobe_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            tx_q        <= tx_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            rd_strobe_q <= rd_strobe_d;
            err_q       <= err_d;
        end
    end

    // Flatten the register file onto the bus-side port.
    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*8 +: 8] = regs_q[g];
    end

    assign tx_data   = tx_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign rd_strobe = rd_strobe_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_regs.sv
// Randomized self-checking bench for spi_cmd_regs against a message-level model.
module tb_spi_cmd_regs;

    localparam int unsigned NREGS = 8;
    localparam int P_IDLE = 0;
    localparam int P_CMD  = 1;
    localparam int P_WR   = 2;
    localparam int P_RD   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 msg_start = 1'b0;
    logic                 msg_end = 1'b0;
    logic                 rx_valid = 1'b0;
    logic [7:0]           rx_data = 8'h00;
    logic [7:0]           tx_data;
    logic [NREGS*8-1:0]   regs_flat;
    logic                 wr_strobe;
    logic [6:0]           wr_addr;
    logic                 rd_strobe;
    logic                 err;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int         m_phase = P_IDLE;
    int         m_addr = 0;
    logic [7:0] m_regs [NREGS];
    logic [7:0] m_tx = 8'hA5;
    logic       m_wr = 1'b0;
    int         m_wa = 0;
    logic       m_rd = 1'b0;
    logic       m_err = 1'b0;

    spi_cmd_regs #(.NREGS(NREGS), .SYNC_BYTE(8'hA5), .OOR_BYTE(8'hFF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_start (msg_start),
        .msg_end   (msg_end),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .rd_strobe (rd_strobe),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge of the protocol rules to the model.
    task automatic model_step();
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_addr  = 0;
            for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
            m_tx = 8'hA5; m_wr = 1'b0; m_wa = 0; m_rd = 1'b0; m_err = 1'b0;
            return;
        end
        m_wr = 1'b0;
        m_rd = 1'b0;
        if (msg_start) begin
            m_phase = P_CMD; m_tx = 8'hA5; m_err = 1'b0;
        end else if (msg_end) begin
            m_phase = P_IDLE; m_tx = 8'hA5;
        end else if (rx_valid) begin
            if (m_phase == P_CMD) begin
                m_addr = int'(rx_data) % 128;
                if (rx_data >= 8'd128) begin
                    m_phase = P_RD;
                    if (m_addr < NREGS) m_tx = m_regs[m_addr];
                    else begin m_tx = 8'hFF; m_err = 1'b1; end
                end else begin
                    m_phase = P_WR;
                    m_tx = 8'h00;
                end
            end else if (m_phase == P_WR) begin
                if (m_addr < NREGS) begin
                    m_regs[m_addr] = rx_data; m_wr = 1'b1; m_wa = m_addr;
                end else begin
                    m_err = 1'b1;
                end
                m_addr = (m_addr + 1) % 128;
            end else if (m_phase == P_RD) begin
                m_rd = 1'b1;
                m_addr = (m_addr + 1) % 128;
                if (m_addr < NREGS) m_tx = m_regs[m_addr];
                else begin m_tx = 8'hFF; m_err = 1'b1; end
            end
        end
    endtask

    task automatic compare_all();
        logic [NREGS*8-1:0] exp_flat;
        for (int i = 0; i < NREGS; i++) exp_flat[i*8 +: 8] = m_regs[i];
        check("regs_flat", 64'(regs_flat), 64'(exp_flat));
        check("tx_data", 64'(tx_data), 64'(m_tx));
        check("wr_strobe", 64'(wr_strobe), 64'(m_wr));
        if (m_wr) check("wr_addr", 64'(wr_addr), 64'(m_wa));
        check("rd_strobe", 64'(rd_strobe), 64'(m_rd));
        check("err", 64'(err), 64'(m_err));
    endtask

    // Drive inputs for one cycle, advance the model, compare away from the edge.
    task automatic step(input logic r, input logic s, input logic e, input logic v, input logic [7:0] d);
        rst_n = r; msg_start = s; msg_end = e; rx_valid = v; rx_data = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();                  step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); endtask
    task automatic start();                 step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00); endtask
    task automatic stop();                  step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); endtask
    task automatic send(input logic [7:0] d); step(1'b1, 1'b0, 1'b0, 1'b1, d); endtask

    initial begin
        @(negedge clk);
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_tx", 64'(tx_data), 64'h A5);
        check("rst_regs", 64'(regs_flat), 64'h0);
        check("rst_wr_addr", 64'(wr_addr), 64'h0);
        idle();

        // Burst write
        start(); send(8'h02);
        send(8'h11);
        check("bw_strobe1", 64'(wr_strobe), 64'h1);
        check("bw_addr1", 64'(wr_addr), 64'h2);
        check("bw_reg2", 64'(regs_flat[23:16]), 64'h11);
        send(8'h22);
        check("bw_addr2", 64'(wr_addr), 64'h3);
        check("bw_reg3", 64'(regs_flat[31:24]), 64'h22);
        stop();
        check("bw_err", 64'(err), 64'h0);

        // Burst read
        start(); send(8'h82);
        check("br_tx0", 64'(tx_data), 64'h11);
        send(8'h00);
        check("br_tx1", 64'(tx_data), 64'h22);
        check("br_rd", 64'(rd_strobe), 64'h1);
        send(8'h00);
        check("br_tx2", 64'(tx_data), 64'h00);
        stop();

        // Out of range write and read
        start(); send(8'h07); send(8'h55);
        check("oor_reg7", 64'(regs_flat[63:56]), 64'h55);
        send(8'h66);
        check("oor_nowr", 64'(wr_strobe), 64'h0);
        check("oor_werr", 64'(err), 64'h1);
        stop();
        start(); send(8'h8A);
        check("oor_rtx", 64'(tx_data), 64'hFF);
        check("oor_rerr", 64'(err), 64'h1);
        stop(); start();
        check("oor_clr", 64'(err), 64'h0);

        // Simultaneous events
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h05);
        send(8'h03);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        check("sim_nowr", 64'(wr_strobe), 64'h0);
        check("sim_reg3", 64'(regs_flat[31:24]), 64'h22);

        // Reset in the middle of a write burst
        start(); send(8'h01); send(8'hAB);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hCD);
        send(8'h44);
        check("mr_regs", 64'(regs_flat), 64'h0);
        check("mr_tx", 64'(tx_data), 64'hA5);
        check("mr_nowr", 64'(wr_strobe), 64'h0);

        // Bytes while idle
        send(8'h83); send(8'h04); send(8'h99);
        check("idle_tx", 64'(tx_data), 64'hA5);

        // Wrap 127 -> 0 on a write burst
        start(); send(8'h7F); send(8'h12); send(8'h34);
        check("wrap_reg0", 64'(regs_flat[7:0]), 64'h34);
        stop();

        // Randomized messages
        for (int m = 0; m < 400; m++) begin
            int r;
            int n;
            logic [7:0] cmd;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++)
                    step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            end else if (r == 1) begin
                send(8'($urandom));
            end
            step(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'($urandom_range(120, 127));
            else cmd[6:0] = 7'($urandom_range(0, 11));
            cmd[7] = 1'($urandom_range(0, 1));
            send(cmd);
            n = $urandom_range(0, 6);
            for (int b = 0; b < n; b++) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle();
                if ($urandom_range(0, 29) == 0)
                    step(1'b1, 1'b1, 1'b0, 1'b1, 8'($urandom));
                else
                    send(8'($urandom));
            end
            step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            if ($urandom_range(0, 1) == 1) idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
